seg7_scan_decoder: RTL and testbench

Reader side of the board's multiplexed 7-segment display bus: samples the active-low segment lines and active-low digit-enable lines, waits for each scanned digit to settle, and converts the segment pattern back into a 4-bit hex value per digit position. It is used as a loop-back checker and a debug capture port alongside the display drivers. It also flags patterns that are not valid hex glyphs.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_pattern_dec.sv | 24 ++
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan reader: glyph table, blank code, FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low glyphs {m,lt,lb,b,rb,rt,t}; element h is the glyph for hex value h.
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } scanState_e;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Inverse glyph lookup: maps an active-low segment pattern back to its hex value.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] hex,
  output logic       isHex,
  output logic       isBlank
);

  always_comb begin
    hex   = '0;
    isHex = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == GLYPHS[i[3:0]]) begin
        hex   = i[3:0];
        isHex = 1'b1;
      end
    end
  end

  assign isBlank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus, waits for each digit to settle,
// and captures the decoded hex value per digit position.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [6:0]           iSEG,
  input  logic [N_DIG-1:0]     iAN,
  output logic [4*N_DIG-1:0]   oDIGITS,
  output logic [N_DIG-1:0]     oVALID,
  output logic [N_DIG-1:0]     oERR,
  output logic                 oUPD,
  output logic [2:0]           oIDX
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);

  logic [6:0]       segMeta, segSync;
  logic [N_DIG-1:0] anMeta, anSync;

  // Synchronizers idle at all-ones so nothing looks selected coming out of reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      segMeta <= '1;
      segSync <= '1;
      anMeta  <= '1;
      anSync  <= '1;
    end else begin
      segMeta <= iSEG;
      segSync <= segMeta;
      anMeta  <= iAN;
      anSync  <= anMeta;
    end
  end

  logic [N_DIG-1:0] anLow;
  logic             oneHot;
  logic [2:0]       curIdx;

  assign anLow  = ~anSync;
  assign oneHot = (anLow != '0) && ((anLow & (anLow - N_DIG'(1))) == '0);

  always_comb begin
    curIdx = '0;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (anLow[k]) curIdx = k[2:0];
    end
  end

  scanState_e       state, stateNext;
  logic [2:0]       idxLat;
  logic [6:0]       patLat;
  logic [CNT_W-1:0] cnt;
  logic             same, atLast;
  logic             relatch, countUp, capture;

  assign same   = (curIdx == idxLat) && (segSync == patLat);
  assign atLast = (cnt == CNT_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (oneHot) stateNext = SETTLE;
      SETTLE:  if (!oneHot) stateNext = IDLE;
               else if (same && atLast) stateNext = HOLD;
      HOLD:    if (!oneHot) stateNext = IDLE;
               else if (!same) stateNext = SETTLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    relatch = 1'b0;
    countUp = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:    relatch = oneHot;
      SETTLE: begin
        relatch = oneHot && !same;
        countUp = oneHot && same && !atLast;
        capture = oneHot && same && atLast;
      end
      HOLD:    relatch = oneHot && !same;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      idxLat <= '0;
      patLat <= SEG_BLANK;
      cnt    <= '0;
    end else if (relatch) begin
      idxLat <= curIdx;
      patLat <= segSync;
      cnt    <= CNT_W'(1);
    end else if (countUp && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  logic [3:0] decHex;
  logic       decIsHex, decIsBlank;

  seg7_pattern_dec uDec (
    .pattern (patLat),
    .hex     (decHex),
    .isHex   (decIsHex),
    .isBlank (decIsBlank)
  );

  logic [N_DIG-1:0][3:0] digits;

  // A bad glyph keeps the digit's old value and only raises the error flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      digits <= '0;
      oVALID <= '0;
      oERR   <= '0;
      oUPD   <= 1'b0;
      oIDX   <= '0;
    end else begin
      oUPD <= capture;
      if (capture) begin
        oIDX <= idxLat;
        for (int unsigned k = 0; k < N_DIG; k++) begin
          if (idxLat == k[2:0]) begin
            if (decIsHex) begin
              digits[k] <= decHex;
              oVALID[k] <= 1'b1;
              oERR[k]   <= 1'b0;
            end else if (decIsBlank) begin
              digits[k] <= '0;
              oVALID[k] <= 1'b0;
              oERR[k]   <= 1'b0;
            end else begin
              oVALID[k] <= 1'b0;
              oERR[k]   <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign oDIGITS = digits;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus is a list of held bus segments,
// expectations come from a segment-level model of the capture rules.
module tb_seg7_scan_decoder;

  localparam int N = 4;
  localparam int S = 8;

  logic             iCLK = 1'b0;
  logic             iRST_N;
  logic [6:0]       iSEG;
  logic [N-1:0]     iAN;
  logic [4*N-1:0]   oDIGITS;
  logic [N-1:0]     oVALID;
  logic [N-1:0]     oERR;
  logic             oUPD;
  logic [2:0]       oIDX;

  always #5 iCLK = ~iCLK;

  seg7_scan_decoder #(.N_DIG(N), .STABLE_CYC(S)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iSEG    (iSEG),
    .iAN     (iAN),
    .oDIGITS (oDIGITS),
    .oVALID  (oVALID),
    .oERR    (oERR),
    .oUPD    (oUPD),
    .oIDX    (oIDX)
  );

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    int             cyc;
    logic [2:0]     idx;
    logic [4*N-1:0] dig;
    logic [N-1:0]   val;
    logic [N-1:0]   err;
  } exp_t;

  exp_t q[$];
  exp_t monE;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [4*N-1:0] expDig;
  logic [N-1:0]   expVal, expErr;
  logic [6:0]     lastSeg;
  logic [N-1:0]   lastAn;
  logic [3+4*N+2*N-1:0] prevOut;

  always @(posedge iCLK) cyc++;

  // Hold one bus state for d cycles; a single active digit held S or more cycles is captured
  // at the (S+2)-th edge after it first appears.
  task automatic seg(input logic [6:0] s, input logic [N-1:0] an, input int d);
    int zeros, pos, hv;
    exp_t e;
    zeros = 0;
    pos   = 0;
    for (int k = 0; k < N; k++) if (!an[k]) begin zeros++; pos = k; end
    if (zeros == 1 && d >= S) begin
      hv = -1;
      for (int h = 0; h < 16; h++) if (s == glyph[h]) hv = h;
      if (hv >= 0) begin
        expDig[pos*4 +: 4] = 4'(hv); expVal[pos] = 1'b1; expErr[pos] = 1'b0;
      end else if (s == 7'h7F) begin
        expDig[pos*4 +: 4] = 4'd0;   expVal[pos] = 1'b0; expErr[pos] = 1'b0;
      end else begin
        expVal[pos] = 1'b0; expErr[pos] = 1'b1;
      end
      e.cyc = cyc + S + 2;
      e.idx = 3'(pos);
      e.dig = expDig;
      e.val = expVal;
      e.err = expErr;
      q.push_back(e);
    end
    iSEG    = s;
    iAN     = an;
    lastSeg = s;
    lastAn  = an;
    repeat (d) @(negedge iCLK);
  endtask

  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oUPD) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_upd cyc=%0d got idx=%0d dig=%h, required no capture", cyc, oIDX, oDIGITS);
        end else begin
          monE = q.pop_front();
          if (cyc !== monE.cyc || oIDX !== monE.idx || oDIGITS !== monE.dig ||
              oVALID !== monE.val || oERR !== monE.err) begin
            bad++;
            $display("FAIL capture got cyc=%0d idx=%0d dig=%h val=%b err=%b, required cyc=%0d idx=%0d dig=%h val=%b err=%b",
                     cyc, oIDX, oDIGITS, oVALID, oERR, monE.cyc, monE.idx, monE.dig, monE.val, monE.err);
          end
        end
      end else begin
        if (q.size() > 0 && cyc > q[0].cyc) begin
          total++;
          bad++;
          $display("FAIL missed_capture cyc=%0d, required capture at cyc=%0d idx=%0d", cyc, q[0].cyc, q[0].idx);
          q.delete(0);
        end
        total++;
        if ({oIDX, oDIGITS, oVALID, oERR} !== prevOut) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d got %h, required %h", cyc, {oIDX, oDIGITS, oVALID, oERR}, prevOut);
        end
      end
    end
    prevOut = {oIDX, oDIGITS, oVALID, oERR};
  end

  initial begin
    logic [6:0]   s;
    logic [N-1:0] a;
    int           d, r;

    iRST_N = 1'b1;
    iSEG   = glyph[2];
    iAN    = 4'b1110;
    expDig = '0;
    expVal = '0;
    expErr = '0;
    lastSeg = '1;
    lastAn  = '1;
    #1 iRST_N = 1'b0;
    #2;
    total++;
    if ({oDIGITS, oVALID, oERR, oUPD, oIDX} !== '0) begin
      bad++;
      $display("FAIL reset_state got dig=%h val=%b err=%b upd=%b idx=%0d, required all zero",
               oDIGITS, oVALID, oERR, oUPD, oIDX);
    end
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    seg(glyph[2], 4'b1110, 12);

    for (int g = 0; g < 16; g++) seg(glyph[g], ~(4'(1) << (g % 4)), 20);

    for (int t = 0; t < 7; t++) seg((t % 2 == 0) ? 7'b0000000 : 7'b1111001, 4'b1011, 5);
    seg(7'b1111001, 4'b1011, 12);

    seg(glyph[7], 4'b1101, 12);
    seg(7'b1110111, 4'b1101, 12);
    seg(7'h7F, 4'b1101, 12);

    seg(glyph[9], 4'b1100, 50);

    seg(glyph[2], 4'b1110, 5);
    #2 iRST_N = 1'b0;
    #1;
    total++;
    if ({oDIGITS, oVALID, oERR, oUPD, oIDX} !== '0) begin
      bad++;
      $display("FAIL async_reset got dig=%h val=%b err=%b upd=%b idx=%0d, required all zero",
               oDIGITS, oVALID, oERR, oUPD, oIDX);
    end
    expDig = '0;
    expVal = '0;
    expErr = '0;
    repeat (2) @(negedge iCLK);
    iRST_N  = 1'b1;
    lastSeg = '1;
    lastAn  = '1;
    seg(glyph[2], 4'b1110, 12);

    for (int t = 0; t < 80; t++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 7)       s = glyph[4'($urandom_range(0, 15))];
        else if (r == 7) s = 7'h7F;
        else             s = 7'($urandom);
        if ($urandom_range(0, 4) == 0) a = N'($urandom);
        else                           a = ~(N'(1) << $urandom_range(0, N - 1));
      end while (s == lastSeg && a == lastAn);
      d = $urandom_range(1, 2 * S + 4);
      seg(s, a, d);
    end

    iAN = '1;
    repeat (S + 10) @(negedge iCLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending captures, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
